// File: rtl/axil_sync_regs.sv
`default_nettype none
// ============================================================================
// Module   : axil_sync_regs
// Desc     : AXI4-Lite slave register bank with read-only status registers.
// Revision : 1.0
// ============================================================================

module axil_sync_regs #(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_ADDR_WIDTH = 8,
  parameter int                    C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,

  input  logic [C_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,

  input  logic [C_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,

  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,

  input  logic [C_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,

  output logic [C_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,

  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   status_in,
  output logic [C_NUM_REGS-1:0]                wr_pulse
);

  localparam int         C_BYTES    = C_DATA_WIDTH / 8;
  localparam int         C_ADDR_LSB = $clog2(C_BYTES);
  localparam int         C_IDX_W    = C_ADDR_WIDTH - C_ADDR_LSB;
  localparam logic [1:0] C_OKAY     = 2'b00;
  localparam logic [1:0] C_SLVERR   = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  wstate_t                  wstate_q, wstate_d;
  rstate_t                  rstate_q, rstate_d;

  logic [C_DATA_WIDTH-1:0]  regs_q [C_NUM_REGS];

  logic                     aw_held_q;
  logic                     w_held_q;
  logic [C_IDX_W-1:0]       wr_idx_q;
  logic [C_DATA_WIDTH-1:0]  wdata_q;
  logic [C_BYTES-1:0]       wstrb_q;
  logic                     bvalid_q;
  logic [1:0]               bresp_q;
  logic [C_NUM_REGS-1:0]    wr_pulse_q;

  logic                     rvalid_q;
  logic [1:0]               rresp_q;
  logic [C_DATA_WIDTH-1:0]  rdata_q;

  logic                     awready;
  logic                     wready;
  logic                     arready;
  logic                     commit;
  logic                     aw_hs;
  logic                     w_hs;
  logic                     ar_hs;
  logic [C_NUM_REGS-1:0]    wr_hit;
  logic                     wr_ok;
  logic [C_IDX_W-1:0]       rd_idx;
  logic                     rd_ok;
  logic [C_DATA_WIDTH-1:0]  rd_data;
  logic                     w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[C_ADDR_LSB-1:0], status_in};

  assign aw_hs  = S_AXI_AWVALID && awready;
  assign w_hs   = S_AXI_WVALID  && wready;
  assign ar_hs  = S_AXI_ARVALID && arready;
  assign rd_idx = S_AXI_ARADDR[C_ADDR_WIDTH-1:C_ADDR_LSB];

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
    end else begin
      wstate_q <= wstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready = !aw_held_q && !ARESET;
        wready  = !w_held_q  && !ARESET;
        if (aw_held_q && w_held_q) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Out-of-range indices match no entry, so they fall out as SLVERR naturally.
  always_comb begin
    for (int n = 0; n < C_NUM_REGS; n++) begin
      wr_hit[n] = (wr_idx_q == C_IDX_W'(n)) && !C_RO_MASK[n];
    end
  end

  assign wr_ok = |wr_hit;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= C_OKAY;
      wr_pulse_q <= '0;
      for (int n = 0; n < C_NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        wr_idx_q  <= S_AXI_AWADDR[C_ADDR_WIDTH-1:C_ADDR_LSB];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_q  <= 1'b0;
        w_held_q   <= 1'b0;
        bvalid_q   <= 1'b1;
        bresp_q    <= wr_ok ? C_OKAY : C_SLVERR;
        wr_pulse_q <= wr_hit;
        for (int n = 0; n < C_NUM_REGS; n++) begin
          for (int b = 0; b < C_BYTES; b++) begin
            if (wr_hit[n] && wstrb_q[b]) begin
              regs_q[n][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
    end else begin
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    arready  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = !ARESET;
        if (S_AXI_ARVALID) begin
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_ok   = 1'b0;
    rd_data = '0;
    for (int n = 0; n < C_NUM_REGS; n++) begin
      if (rd_idx == C_IDX_W'(n)) begin
        rd_ok   = 1'b1;
        rd_data = C_RO_MASK[n] ? status_in[n*C_DATA_WIDTH +: C_DATA_WIDTH] : regs_q[n];
      end
    end
  end

  // regs_q is sampled before any same-edge commit lands, giving pre-commit data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= C_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_ok ? C_OKAY : C_SLVERR;
      rdata_q  <= rd_data;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  // ------------------------------------------------------------------ outputs
  generate
    for (genvar n = 0; n < C_NUM_REGS; n++) begin : g_reg_out
      assign reg_out[n*C_DATA_WIDTH +: C_DATA_WIDTH] = C_RO_MASK[n] ? '0 : regs_q[n];
    end
  endgenerate

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_sync_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_sync_regs
// Desc     : Scoreboard bench for axil_sync_regs against a register-array model.
// Revision : 1.0
// ============================================================================

module tb_axil_sync_regs;

  localparam int             DW = 32;
  localparam int             AW = 8;
  localparam int             NR = 8;
  localparam logic [NR-1:0]  RO = 8'h04;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, wvalid, arvalid, bready, rready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [DW-1:0]     rdata;
  logic [NR*DW-1:0]  reg_out, status_in;
  logic [NR-1:0]     wr_pulse;

  always #5 clk = ~clk;

  axil_sync_regs #(
    .C_DATA_WIDTH (DW),
    .C_ADDR_WIDTH (AW),
    .C_NUM_REGS   (NR),
    .C_RO_MASK    (RO)
  ) u_dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .status_in     (status_in),
    .wr_pulse      (wr_pulse)
  );

  // Reference model: one word per register plus expected-response queues.
  logic [DW-1:0] mdl [NR];
  logic [1:0]    bq [$];
  logic [33:0]   rq [$];
  logic [1:0]    b_exp;
  logic [33:0]   r_exp;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NR*DW-1:0] exp_regout();
    logic [NR*DW-1:0] r;
    r = '0;
    for (int n = 0; n < NR; n++) r[n*DW +: DW] = RO[n] ? '0 : mdl[n];
    return r;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < NR; n++) mdl[n] = '0;
  endfunction

  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) check("b_unexpected", bq.size(), 1);
      else begin
        b_exp = bq.pop_front();
        check("bresp", bresp, b_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) check("r_unexpected", rq.size(), 1);
      else begin
        r_exp = rq.pop_front();
        check("rdata", rdata, r_exp[33:2]);
        check("rresp", rresp, r_exp[1:0]);
      end
    end
  end

  task automatic send_aw(input logic [AW-1:0] a, input int d);
    int t;
    repeat (d) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) check("aw_timeout", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] dat, input logic [3:0] s, input int d);
    int t;
    repeat (d) begin @(posedge clk); #1; end
    wdata = dat; wstrb = s; wvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!wready && t < 50) begin @(negedge clk); t++; end
    if (!wready) check("w_timeout", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] dat, input logic [3:0] s,
                          input int awd, input int wd);
    int               idx, t;
    bit               ok;
    logic [NR-1:0]    pulse;
    logic [NR*DW-1:0] pre;
    idx   = int'(a >> 2);
    ok    = (idx < NR) && !RO[idx];
    pre   = exp_regout();
    pulse = ok ? NR'(1 << idx) : '0;
    bq.push_back(ok ? 2'b00 : 2'b10);
    if (ok) for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = dat[b*8 +: 8];
    @(posedge clk); #1;
    fork
      send_aw(a, awd);
      send_w(dat, s, wd);
      begin
        if (awd > 0) begin
          repeat (awd) @(negedge clk);
          check("early_bvalid", bvalid, 0);
          check("early_pulse", wr_pulse, 0);
          check("early_regout", reg_out, pre);
        end
      end
    join
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    check("bvalid", bvalid, 1);
    check("wr_pulse", wr_pulse, pulse);
    check("reg_out", reg_out, exp_regout());
    @(negedge clk);
    check("wr_pulse_1cyc", wr_pulse, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int t, idx;
    idx = int'(a >> 2);
    if (idx >= NR)   rq.push_back({32'h0, 2'b10});
    else if (RO[idx]) rq.push_back({status_in[idx*DW +: DW], 2'b00});
    else             rq.push_back({mdl[idx], 2'b00});
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) check("ar_timeout", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", rvalid, 1);
  endtask

  logic [1:0]  b_hold;
  logic [33:0] r_hold;
  logic [7:0]  ra;

  initial begin
    rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    status_in = '0;
    for (int n = 0; n < NR; n++) status_in[n*DW +: DW] = $urandom;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("awready_after_rst", awready, 1);
    check("wready_after_rst", wready, 1);
    check("arready_after_rst", arready, 1);
    check("bvalid_rst", bvalid, 0);
    check("rvalid_rst", rvalid, 0);
    check("rdata_rst", rdata, 0);
    check("resp_rst", {bresp, rresp}, 0);
    check("regout_rst", reg_out, 0);
    check("pulse_rst", wr_pulse, 0);

    // W leads AW by 3 cycles, partial strobes
    do_write(8'h04, 32'hAABBCCDD, 4'b0101, 3, 0);
    check("partial_strobe", reg_out[63:32], 32'h00BB00DD);

    // Sequential write/readback (reg 2 is read-only in this build)
    for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) do_read(8'(i * 4));

    // Out of range
    do_write(8'h20, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(8'h20);

    // Read-only status register
    status_in[2*DW +: DW] = 32'h12345678;
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, 1, 0);
    do_read(8'h08);

    // Zero strobe still pulses
    do_write(8'h0C, 32'h55555555, 4'h0, 0, 2);

    // Back-pressure on B and R
    bready = 1'b0; rready = 1'b0;
    do_write(8'h18, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(8'h18);
    b_hold = bresp;
    r_hold = {rdata, rresp};
    @(posedge clk); #1;
    awaddr = 8'h1C; awvalid = 1'b1; araddr = 8'h1C; arvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_bvalid", bvalid, 1);
      check("bp_bresp", bresp, b_hold);
      check("bp_rvalid", rvalid, 1);
      check("bp_rfields", {rdata, rresp}, r_hold);
      check("bp_awready", awready, 0);
      check("bp_arready", arready, 0);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    do_write(8'h1C, 32'h0BADCAFE, 4'hF, 0, 0);
    do_read(8'h1C);

    // Reset between AW and W abandons the write
    @(posedge clk); #1;
    awaddr = 8'h14; awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 1'b0; rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_wready", wready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_awready", awready, 1);
    repeat (4) begin
      @(negedge clk);
      check("midrst_bvalid", bvalid, 0);
    end
    check("midrst_regout", reg_out, 0);
    do_write(8'h14, 32'h13579BDF, 4'hF, 0, 0);
    do_read(8'h14);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom_range(0, 8'h27));
      if ($urandom_range(0, 3) == 0) status_in[($urandom_range(0, NR - 1))*DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(ra);
    end

    repeat (4) @(negedge clk);
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
